// File: rtl/decode_operand_stage_if.sv
// Fetch-to-decode handshake: fetch drives in_valid/in_instr, decode answers with in_ready.
// An instruction transfers on a rising clk edge where in_valid && in_ready; while in_ready
// is low the fetch side holds in_instr stable and re-presents it the next cycle.
interface decode_operand_stage_if #(
    parameter int DATA_W = 24
);
    logic              in_valid;
    logic [DATA_W-1:0] in_instr;
    logic              in_ready;

    modport master (
        output in_valid,
        output in_instr,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_instr,
        output in_ready
    );
endinterface

// File: rtl/decode_operand_stage.sv
// Decode/operand-fetch stage: decodes one instruction per cycle, forwards EX/WB results,
// stalls on load-use, flushes on taken branch. Optional macro DECODE_PERF_CNT_EN adds counters.
module decode_operand_stage #(
    parameter int DATA_W = 24
) (
    input  logic              clk,
    input  logic              rst,
    decode_operand_stage_if.slave fetch,
    input  logic              flush,
    output logic [3:0]        rf_read_addr_1,
    output logic [3:0]        rf_read_addr_2,
    input  logic [DATA_W-1:0] rf_read_data_1,
    input  logic [DATA_W-1:0] rf_read_data_2,
    input  logic              ex_wr_en,
    input  logic [3:0]        ex_wr_dest,
    input  logic [DATA_W-1:0] ex_wr_data,
    input  logic              ex_is_load,
    input  logic              wb_wr_en,
    input  logic [3:0]        wb_wr_dest,
    input  logic [DATA_W-1:0] wb_wr_data,
`ifdef DECODE_PERF_CNT_EN
    output logic [15:0]       stall_count,
    output logic [15:0]       flush_count,
`endif
    output logic              out_valid,
    output logic [3:0]        out_opcode,
    output logic [3:0]        out_rd,
    output logic              out_wr_en,
    output logic              out_is_load,
    output logic [DATA_W-1:0] out_op_a,
    output logic [DATA_W-1:0] out_op_b,
    output logic [DATA_W-1:0] out_imm
);

    localparam logic [3:0] OP_LOAD   = 4'hC;
    localparam logic [3:0] OP_STORE  = 4'hD;
    localparam logic [3:0] OP_BRANCH = 4'hE;
    localparam logic [3:0] OP_NOP    = 4'hF;

    logic [3:0]        opcode;
    logic [3:0]        rd;
    logic [3:0]        rs1;
    logic [3:0]        rs2;
    logic [11:0]       imm12;
    logic              is_r_type;
    logic              is_i_type;
    logic              is_load;
    logic              uses_rs1;
    logic              uses_rs2;
    logic              writes_rd;
    logic              hazard;
    logic              stall;
    logic              accept;
    logic [DATA_W-1:0] imm_ext;
    logic [DATA_W-1:0] src_a;
    logic [DATA_W-1:0] src_b;

    logic              out_valid_q,   out_valid_d;
    logic [3:0]        out_opcode_q,  out_opcode_d;
    logic [3:0]        out_rd_q,      out_rd_d;
    logic              out_wr_en_q,   out_wr_en_d;
    logic              out_is_load_q, out_is_load_d;
    logic [DATA_W-1:0] out_op_a_q,    out_op_a_d;
    logic [DATA_W-1:0] out_op_b_q,    out_op_b_d;
    logic [DATA_W-1:0] out_imm_q,     out_imm_d;

    // Priority: r0, then the younger EX result, then WB (same-edge regfile write), then regfile.
    function automatic logic [DATA_W-1:0] resolve(
        input logic              used,
        input logic [3:0]        src,
        input logic [DATA_W-1:0] rf_data,
        input logic              ex_en,
        input logic [3:0]        ex_dest,
        input logic [DATA_W-1:0] ex_data,
        input logic              wb_en,
        input logic [3:0]        wb_dest,
        input logic [DATA_W-1:0] wb_data
    );
        logic [DATA_W-1:0] r;
        r = '0;
        if (!used || src == 4'd0) begin
            r = '0;
        end else if (ex_en && ex_dest == src) begin
            r = ex_data;
        end else if (wb_en && wb_dest == src) begin
            r = wb_data;
        end else begin
            r = rf_data;
        end
        return r;
    endfunction

    always_comb begin
        opcode    = fetch.in_instr[23:20];
        rd        = fetch.in_instr[19:16];
        rs1       = fetch.in_instr[15:12];
        rs2       = fetch.in_instr[11:8];
        imm12     = fetch.in_instr[11:0];

        is_r_type = (opcode[3] == 1'b0);
        is_i_type = (opcode[3:2] == 2'b10);
        is_load   = (opcode == OP_LOAD);
        uses_rs1  = (opcode != OP_NOP);
        uses_rs2  = is_r_type || (opcode == OP_STORE) || (opcode == OP_BRANCH);
        writes_rd = is_r_type || is_i_type || is_load;
        imm_ext   = {{(DATA_W-12){imm12[11]}}, imm12};
    end

    assign rf_read_addr_1 = rs1;
    assign rf_read_addr_2 = rs2;

    // A loaded value is not available until WB; only real, used sources can hazard.
    always_comb begin
        hazard = fetch.in_valid && ex_is_load && ex_wr_en && (ex_wr_dest != 4'd0) &&
                 ((uses_rs1 && ex_wr_dest == rs1) || (uses_rs2 && ex_wr_dest == rs2));
        stall  = hazard && !flush;
        accept = fetch.in_valid && !stall && !flush;
    end

    assign fetch.in_ready = rst || !stall;

    always_comb begin
        src_a = resolve(uses_rs1, rs1, rf_read_data_1, ex_wr_en, ex_wr_dest, ex_wr_data,
                        wb_wr_en, wb_wr_dest, wb_wr_data);
        src_b = resolve(uses_rs2, rs2, rf_read_data_2, ex_wr_en, ex_wr_dest, ex_wr_data,
                        wb_wr_en, wb_wr_dest, wb_wr_data);
    end

    // Bubbles (stall, flush, no input) are registered as a canonical nop bundle.
    always_comb begin
        out_valid_d   = 1'b0;
        out_opcode_d  = OP_NOP;
        out_rd_d      = 4'd0;
        out_wr_en_d   = 1'b0;
        out_is_load_d = 1'b0;
        out_op_a_d    = '0;
        out_op_b_d    = '0;
        out_imm_d     = '0;
        if (accept) begin
            out_valid_d   = 1'b1;
            out_opcode_d  = opcode;
            out_rd_d      = rd;
            out_wr_en_d   = writes_rd && (rd != 4'd0);
            out_is_load_d = is_load;
            out_op_a_d    = src_a;
            out_op_b_d    = (is_i_type || is_load) ? imm_ext : src_b;
            out_imm_d     = imm_ext;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q   <= 1'b0;
            out_opcode_q  <= OP_NOP;
            out_rd_q      <= 4'd0;
            out_wr_en_q   <= 1'b0;
            out_is_load_q <= 1'b0;
            out_op_a_q    <= '0;
            out_op_b_q    <= '0;
            out_imm_q     <= '0;
        end else begin
            out_valid_q   <= out_valid_d;
            out_opcode_q  <= out_opcode_d;
            out_rd_q      <= out_rd_d;
            out_wr_en_q   <= out_wr_en_d;
            out_is_load_q <= out_is_load_d;
            out_op_a_q    <= out_op_a_d;
            out_op_b_q    <= out_op_b_d;
            out_imm_q     <= out_imm_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_opcode  = out_opcode_q;
    assign out_rd      = out_rd_q;
    assign out_wr_en   = out_wr_en_q;
    assign out_is_load = out_is_load_q;
    assign out_op_a    = out_op_a_q;
    assign out_op_b    = out_op_b_q;
    assign out_imm     = out_imm_q;

`ifdef DECODE_PERF_CNT_EN
    logic [15:0] stall_count_q, stall_count_d;
    logic [15:0] flush_count_q, flush_count_d;

    always_comb begin
        stall_count_d = stall_count_q;
        flush_count_d = flush_count_q;
        if (stall && stall_count_q != 16'hFFFF) begin
            stall_count_d = stall_count_q + 16'd1;
        end
        if (flush && flush_count_q != 16'hFFFF) begin
            flush_count_d = flush_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_count_q <= 16'd0;
            flush_count_q <= 16'd0;
        end else begin
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    assign stall_count = stall_count_q;
    assign flush_count = flush_count_q;
`endif

endmodule

// File: tb/tb_decode_operand_stage.sv
// Directed bench for decode_operand_stage: hand-computed vectors for decode, forwarding,
// load-use stall, flush and reset; counter checks when DECODE_PERF_CNT_EN is defined.
module tb_decode_operand_stage;

  logic        clk;
  logic        rst;
  logic        flush;
  logic [3:0]  rf_read_addr_1, rf_read_addr_2;
  logic [23:0] rf_read_data_1, rf_read_data_2;
  logic        ex_wr_en, ex_is_load, wb_wr_en;
  logic [3:0]  ex_wr_dest, wb_wr_dest;
  logic [23:0] ex_wr_data, wb_wr_data;
  logic        out_valid, out_wr_en, out_is_load;
  logic [3:0]  out_opcode, out_rd;
  logic [23:0] out_op_a, out_op_b, out_imm;
`ifdef DECODE_PERF_CNT_EN
  logic [15:0] stall_count, flush_count;
  int          exp_stalls;
  int          exp_flushes;
`endif

  int total;
  int bad;

  decode_operand_stage_if #(.DATA_W(24)) fe_if ();

  decode_operand_stage #(.DATA_W(24)) dut (
    .clk            (clk),
    .rst            (rst),
    .fetch          (fe_if.slave),
    .flush          (flush),
    .rf_read_addr_1 (rf_read_addr_1),
    .rf_read_addr_2 (rf_read_addr_2),
    .rf_read_data_1 (rf_read_data_1),
    .rf_read_data_2 (rf_read_data_2),
    .ex_wr_en       (ex_wr_en),
    .ex_wr_dest     (ex_wr_dest),
    .ex_wr_data     (ex_wr_data),
    .ex_is_load     (ex_is_load),
    .wb_wr_en       (wb_wr_en),
    .wb_wr_dest     (wb_wr_dest),
    .wb_wr_data     (wb_wr_data),
`ifdef DECODE_PERF_CNT_EN
    .stall_count    (stall_count),
    .flush_count    (flush_count),
`endif
    .out_valid      (out_valid),
    .out_opcode     (out_opcode),
    .out_rd         (out_rd),
    .out_wr_en      (out_wr_en),
    .out_is_load    (out_is_load),
    .out_op_a       (out_op_a),
    .out_op_b       (out_op_b),
    .out_imm        (out_imm)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // checker
  task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_instr(input logic valid, input logic [23:0] instr);
    fe_if.in_valid = valid;
    fe_if.in_instr = instr;
  endtask

  task automatic drive_ex(input logic en, input logic [3:0] dest, input logic [23:0] data,
                          input logic ld);
    ex_wr_en   = en;
    ex_wr_dest = dest;
    ex_wr_data = data;
    ex_is_load = ld;
  endtask

  task automatic drive_wb(input logic en, input logic [3:0] dest, input logic [23:0] data);
    wb_wr_en   = en;
    wb_wr_dest = dest;
    wb_wr_data = data;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_valid"},  24'(out_valid),   24'd0);
    chk({tag, "_wr_en"},  24'(out_wr_en),   24'd0);
    chk({tag, "_isld"},   24'(out_is_load), 24'd0);
    chk({tag, "_opcode"}, 24'(out_opcode),  24'hF);
    chk({tag, "_rd"},     24'(out_rd),      24'd0);
    chk({tag, "_op_a"},   out_op_a,         24'd0);
    chk({tag, "_op_b"},   out_op_b,         24'd0);
    chk({tag, "_imm"},    out_imm,          24'd0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
`ifdef DECODE_PERF_CNT_EN
    exp_stalls  = 0;
    exp_flushes = 0;
`endif
    rst   = 1'b1;
    flush = 1'b0;
    rf_read_data_1 = 24'd0;
    rf_read_data_2 = 24'd0;
    drive_wb(1'b0, 4'd0, 24'd0);
    // hazard-looking inputs while in reset: in_ready must still be 1
    drive_instr(1'b1, 24'h174300);
    drive_ex(1'b1, 4'd3, 24'h000111, 1'b1);
    tick();
    tick();
    chk_reset_vals("reset");
    chk("reset_in_ready", 24'(fe_if.in_ready), 24'd1);
    drive_ex(1'b0, 4'd0, 24'd0, 1'b0);
    drive_instr(1'b0, 24'hF00000);
    rst = 1'b0;
    #1;
    chk("post_reset_in_ready", 24'(fe_if.in_ready), 24'd1);

    // plain R-type: op0 rd6 rs1=1 rs2=2
    rf_read_data_1 = 24'h001000;
    rf_read_data_2 = 24'h01CAC5;
    drive_instr(1'b1, 24'h061200);
    #1;
    chk("r_addr1", 24'(rf_read_addr_1), 24'd1);
    chk("r_addr2", 24'(rf_read_addr_2), 24'd2);
    chk("r_in_ready", 24'(fe_if.in_ready), 24'd1);
    tick();
    chk("r_valid",  24'(out_valid),  24'd1);
    chk("r_opcode", 24'(out_opcode), 24'h0);
    chk("r_rd",     24'(out_rd),     24'd6);
    chk("r_wr_en",  24'(out_wr_en),  24'd1);
    chk("r_isld",   24'(out_is_load), 24'd0);
    chk("r_op_a",   out_op_a,        24'h001000);
    chk("r_op_b",   out_op_b,        24'h01CAC5);
    chk("r_imm",    out_imm,         24'h000200);

    // forwarding: I-type op8 rd5 rs1=1 imm=0x123; EX beats WB
    rf_read_data_1 = 24'h000777;
    drive_instr(1'b1, 24'h851123);
    drive_ex(1'b1, 4'd1, 24'h000ABC, 1'b0);
    drive_wb(1'b1, 4'd1, 24'h000123);
    tick();
    chk("fwd_ex_op_a", out_op_a, 24'h000ABC);
    chk("fwd_ex_op_b", out_op_b, 24'h000123);
    drive_ex(1'b0, 4'd1, 24'h000ABC, 1'b0);
    tick();
    chk("fwd_wb_op_a", out_op_a, 24'h000123);
    drive_wb(1'b0, 4'd0, 24'd0);
    tick();
    chk("fwd_rf_op_a", out_op_a, 24'h000777);
    // rs1=0 with EX dest 0 writing: operand must be 0
    rf_read_data_1 = 24'h000555;
    drive_instr(1'b1, 24'h850123);
    drive_ex(1'b1, 4'd0, 24'h000ABC, 1'b0);
    tick();
    chk("fwd_r0_op_a", out_op_a, 24'h000000);

    // load-use: EX load to r3, R-type op1 rd7 rs1=4 rs2=3
    rf_read_data_1 = 24'h000044;
    rf_read_data_2 = 24'h000000;
    drive_instr(1'b1, 24'h174300);
    drive_ex(1'b1, 4'd3, 24'h000999, 1'b1);
    #1;
    chk("lu_in_ready", 24'(fe_if.in_ready), 24'd0);
    tick();
`ifdef DECODE_PERF_CNT_EN
    exp_stalls++;
`endif
    chk("lu_bubble_valid", 24'(out_valid), 24'd0);
    chk("lu_bubble_wr_en", 24'(out_wr_en), 24'd0);
    // load moved to WB; same instruction re-presented
    drive_ex(1'b0, 4'd0, 24'd0, 1'b0);
    drive_wb(1'b1, 4'd3, 24'h00BEEF);
    #1;
    chk("lu_release_ready", 24'(fe_if.in_ready), 24'd1);
    tick();
    chk("lu_valid", 24'(out_valid), 24'd1);
    chk("lu_op_a",  out_op_a, 24'h000044);
    chk("lu_op_b",  out_op_b, 24'h00BEEF);
    chk("lu_rd",    24'(out_rd), 24'd7);
    drive_wb(1'b0, 4'd0, 24'd0);

    // flush during a load-use hazard
    drive_ex(1'b1, 4'd3, 24'h000999, 1'b1);
    flush = 1'b1;
    #1;
    chk("fl_in_ready", 24'(fe_if.in_ready), 24'd1);
    tick();
`ifdef DECODE_PERF_CNT_EN
    exp_flushes++;
`endif
    chk("fl_valid", 24'(out_valid), 24'd0);
    chk("fl_wr_en", 24'(out_wr_en), 24'd0);
    flush = 1'b0;
    drive_ex(1'b0, 4'd0, 24'd0, 1'b0);
    drive_instr(1'b1, 24'h061200);
    rf_read_data_1 = 24'h001000;
    rf_read_data_2 = 24'h01CAC5;
    #1;
    chk("fl_next_ready", 24'(fe_if.in_ready), 24'd1);
    tick();
    chk("fl_next_valid", 24'(out_valid), 24'd1);

    // I-type negative imm: op9 rd2 rs1=0 imm=0x800
    drive_instr(1'b1, 24'h920800);
    tick();
    chk("i_imm",   out_imm,  24'hFFF800);
    chk("i_op_b",  out_op_b, 24'hFFF800);
    chk("i_op_a",  out_op_a, 24'h000000);
    chk("i_wr_en", 24'(out_wr_en), 24'd1);

    // load instruction: opC rd4 rs1=2 imm=0x010
    rf_read_data_1 = 24'h000300;
    drive_instr(1'b1, 24'hC42010);
    tick();
    chk("ld_isld",  24'(out_is_load), 24'd1);
    chk("ld_op_a",  out_op_a, 24'h000300);
    chk("ld_op_b",  out_op_b, 24'h000010);

    // unused source: I-type whose imm bits alias rs2=3 must not stall on EX load to r3
    drive_instr(1'b1, 24'h810300);
    drive_ex(1'b1, 4'd3, 24'h000999, 1'b1);
    #1;
    chk("unused_src_ready", 24'(fe_if.in_ready), 24'd1);
    tick();
    chk("unused_src_valid", 24'(out_valid), 24'd1);
    drive_ex(1'b0, 4'd0, 24'd0, 1'b0);

    // store: no write; R-type to r0: no write
    drive_instr(1'b1, 24'hD51200);
    tick();
    chk("st_wr_en",  24'(out_wr_en), 24'd0);
    chk("st_op_b",   out_op_b, 24'h01CAC5);
    drive_instr(1'b1, 24'h201200);
    tick();
    chk("rd0_wr_en", 24'(out_wr_en), 24'd0);
    chk("rd0_valid", 24'(out_valid), 24'd1);

    // no in_valid: bubble with in_ready high
    drive_instr(1'b0, 24'h061200);
    #1;
    chk("idle_ready", 24'(fe_if.in_ready), 24'd1);
    tick();
    chk("idle_valid", 24'(out_valid), 24'd0);
    chk("idle_wr_en", 24'(out_wr_en), 24'd0);

`ifdef DECODE_PERF_CNT_EN
    chk("cnt_stall", 24'(stall_count), 24'(exp_stalls));
    chk("cnt_flush", 24'(flush_count), 24'(exp_flushes));
`endif

    // reset asserted mid-stall drops the held instruction
    drive_instr(1'b1, 24'h174300);
    drive_ex(1'b1, 4'd3, 24'h000999, 1'b1);
    tick();
`ifdef DECODE_PERF_CNT_EN
    exp_stalls++;
`endif
    chk("rs_stall_ready", 24'(fe_if.in_ready), 24'd0);
    rst = 1'b1;
#1;
    chk_reset_vals("rs_async");
    chk("rs_in_ready", 24'(fe_if.in_ready), 24'd1);
    tick();
    chk("rs_hold_ready", 24'(fe_if.in_ready), 24'd1);
    drive_ex(1'b0, 4'd0, 24'd0, 1'b0);
    drive_instr(1'b0, 24'hF00000);
    rst = 1'b0;
`ifdef DECODE_PERF_CNT_EN
    exp_stalls  = 0;
    exp_flushes = 0;
`endif
    #1;
    chk("rs_after_ready", 24'(fe_if.in_ready), 24'd1);
    tick();
    chk("rs_after_valid", 24'(out_valid), 24'd0);
`ifdef DECODE_PERF_CNT_EN
    chk("cnt_stall_clr", 24'(stall_count), 24'(exp_stalls));
    chk("cnt_flush_clr", 24'(flush_count), 24'(exp_flushes));
`endif

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
